phase1_sequencer: RTL and testbench

Downstream controller for the Phase 1 puzzle stages. It enables one puzzle at a time and consumes each puzzle's clear/fail pulses. It counts strikes, applies a lockout after each fail, and advances through the puzzles. It drives the shared 7-segment and LED outputs and reports phase completion or game over to the top-level game FSM.

---
 rtl/phase1_pkg.sv | 19 +
 rtl/phase1_lockout_timer.sv | 27 ++
 rtl/phase1_sequencer.sv | 163 ++++++++++++++++
 tb/tb_phase1_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/phase1_pkg.sv
// Shared state encoding and display constants for the Phase 1 sequencer.
package phase1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LOCKOUT,
        S_ADVANCE,
        S_DONE,
        S_OVER
    } state_e;

    localparam logic [31:0] SEG_LOCKOUT = 32'hEEEE_EEEE;
    localparam logic [31:0] SEG_DONE    = 32'h0000_600D;
    localparam logic [31:0] SEG_OVER    = 32'h0000_DEAD;
    localparam logic [7:0]  LED_LOCKOUT = 8'hFF;
    localparam logic [7:0]  LED_OFF     = 8'h00;

endpackage

// File: rtl/phase1_lockout_timer.sv
// Loadable down-counter; tc is high while enabled and the count has reached zero.
module phase1_lockout_timer #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign tc = en && (count_q == '0);

endmodule

// File: rtl/phase1_sequencer.sv
// Phase 1 controller: enables puzzles in order, tracks strikes, applies lockout
// after each fail and reports phase completion or game over. All outputs registered.
module phase1_sequencer
    import phase1_pkg::*;
#(
    parameter int NUM_PUZZLES    = 3,
    parameter int MAX_STRIKES    = 3,
    parameter int LOCKOUT_CYCLES = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      timer_expired,
    input  logic [NUM_PUZZLES-1:0]    puz_clear,
    input  logic [NUM_PUZZLES-1:0]    puz_fail,
    input  logic [32*NUM_PUZZLES-1:0] puz_seg_data,
    input  logic [8*NUM_PUZZLES-1:0]  puz_led,
    output logic [NUM_PUZZLES-1:0]    puz_enable,
    output logic [1:0]                cur_puzzle,
    output logic [1:0]                strikes,
    output logic [31:0]               seg_data,
    output logic [7:0]                led_out,
    output logic                      busy,
    output logic                      phase_clear,
    output logic                      game_over
);

    localparam int              CNT_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]      LAST_IDX  = 2'(NUM_PUZZLES - 1);
    localparam logic [1:0]      MAX_STK   = 2'(MAX_STRIKES);

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v >= MAX_STK) ? MAX_STK : v + 2'd1;
    endfunction

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  stk_q, stk_d;
    logic        cur_clear, cur_fail;
    logic [31:0] sel_seg;
    logic [7:0]  sel_led;
    logic        lock_load, lock_en, lock_tc;

    assign lock_en = (state_q == S_LOCKOUT);

    phase1_lockout_timer #(.WIDTH(CNT_W)) u_lockout_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .en       (lock_en),
        .load_val (LOCK_LOAD),
        .tc       (lock_tc)
    );

    // Only the active puzzle's pulses are visible to the FSM.
    always_comb begin
        cur_clear = 1'b0;
        cur_fail  = 1'b0;
        for (int i = 0; i < NUM_PUZZLES; i++) begin
            if (idx_q == 2'(i)) begin
                cur_clear = puz_clear[i];
                cur_fail  = puz_fail[i];
            end
        end
    end

    always_comb begin
        sel_seg = '0;
        sel_led = '0;
        for (int i = 0; i < NUM_PUZZLES; i++) begin
            if (idx_d == 2'(i)) begin
                sel_seg = puz_seg_data[32*i +: 32];
                sel_led = puz_led[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stk_d     = stk_q;
        lock_load = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            stk_d   = 2'd0;
        end else if (timer_expired && (state_q == S_RUN || state_q == S_LOCKOUT)) begin
            state_d = S_OVER;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        idx_d   = 2'd0;
                        stk_d   = 2'd0;
                    end
                end
                S_RUN: begin
                    if (cur_clear) begin
                        state_d = S_ADVANCE;
                    end else if (cur_fail) begin
                        stk_d = sat_inc(stk_q);
                        if (sat_inc(stk_q) == MAX_STK) begin
                            state_d = S_OVER;
                        end else begin
                            state_d   = S_LOCKOUT;
                            lock_load = 1'b1;
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (lock_tc) state_d = S_RUN;
                end
                S_ADVANCE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            stk_q       <= 2'd0;
            puz_enable  <= '0;
            seg_data    <= '0;
            led_out     <= '0;
            busy        <= 1'b0;
            phase_clear <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            stk_q       <= stk_d;
            busy        <= (state_d == S_RUN) || (state_d == S_LOCKOUT) || (state_d == S_ADVANCE);
            phase_clear <= (state_d == S_DONE);
            game_over   <= (state_d == S_OVER);
            puz_enable  <= (state_d == S_RUN) ? (NUM_PUZZLES'(1) << idx_d) : '0;
            case (state_d)
                S_IDLE:    begin seg_data <= '0;          led_out <= LED_OFF;     end
                S_RUN:     begin seg_data <= sel_seg;     led_out <= sel_led;     end
                S_LOCKOUT: begin seg_data <= SEG_LOCKOUT; led_out <= LED_LOCKOUT; end
                S_DONE:    begin seg_data <= SEG_DONE;    led_out <= LED_OFF;     end
                S_OVER:    begin seg_data <= SEG_OVER;    led_out <= LED_OFF;     end
                default: ;
            endcase
        end
    end

    assign cur_puzzle = idx_q;
    assign strikes    = stk_q;

endmodule

// File: tb/tb_phase1_sequencer.sv
// Directed bench for phase1_sequencer with LOCKOUT_CYCLES=4, MAX_STRIKES=3.
module tb_phase1_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, timer_expired;
    logic [2:0]  puz_clear, puz_fail;
    logic [95:0] puz_seg_data;
    logic [23:0] puz_led;
    logic [2:0]  puz_enable;
    logic [1:0]  cur_puzzle, strikes;
    logic [31:0] seg_data;
    logic [7:0]  led_out;
    logic        busy, phase_clear, game_over;

    int n_err = 0;
    int n_chk = 0;

    localparam logic [31:0] SEG0 = 32'hAAAA_0000;
    localparam logic [31:0] SEG1 = 32'hBBBB_0001;
    localparam logic [31:0] SEG2 = 32'hCCCC_0002;
    localparam logic [31:0] SEGL = 32'hEEEE_EEEE;
    localparam logic [31:0] SEGD = 32'h0000_600D;
    localparam logic [31:0] SEGO = 32'h0000_DEAD;

    phase1_sequencer #(
        .NUM_PUZZLES    (3),
        .MAX_STRIKES    (3),
        .LOCKOUT_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .timer_expired (timer_expired),
        .puz_clear     (puz_clear),
        .puz_fail      (puz_fail),
        .puz_seg_data  (puz_seg_data),
        .puz_led       (puz_led),
        .puz_enable    (puz_enable),
        .cur_puzzle    (cur_puzzle),
        .strikes       (strikes),
        .seg_data      (seg_data),
        .led_out       (led_out),
        .busy          (busy),
        .phase_clear   (phase_clear),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        st, ab, te;
        logic [2:0]  clr, fl;
        logic [2:0]  en;
        logic [1:0]  cp, stk;
        logic [31:0] seg;
        logic [7:0]  led;
        logic        bsy, pc, go, dchk;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, ab, te, input logic [2:0] clr, fl, en,
                                input logic [1:0] cp, stk, input logic [31:0] seg,
                                input logic [7:0] led, input logic bsy, pc, go, dchk);
        vec_t v;
        v = '{st, ab, te, clr, fl, en, cp, stk, seg, led, bsy, pc, go, dchk};
        return v;
    endfunction

    task automatic step(input logic s, a, t, input logic [2:0] c, f);
        start = s; abort = a; timer_expired = t; puz_clear = c; puz_fail = f;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; timer_expired = 1'b0; puz_clear = 3'b000; puz_fail = 3'b000;
    endtask

    task automatic chk(input string nm, input logic [2:0] e_en, input logic [1:0] e_cp, e_stk,
                       input logic [31:0] e_seg, input logic [7:0] e_led,
                       input logic e_bsy, e_pc, e_go, e_dchk);
        logic [9:0]  act_c, exp_c;
        logic [39:0] act_d, exp_d;
        act_c = {puz_enable, cur_puzzle, strikes, busy, phase_clear, game_over};
        exp_c = {e_en, e_cp, e_stk, e_bsy, e_pc, e_go};
        n_chk++;
        if (act_c !== exp_c) begin
            n_err++;
            $display("FAIL %s ctrl {en,cp,stk,busy,pc,go}: got %b required %b", nm, act_c, exp_c);
        end
        if (e_dchk) begin
            act_d = {seg_data, led_out};
            exp_d = {e_seg, e_led};
            n_chk++;
            if (act_d !== exp_d) begin
                n_err++;
                $display("FAIL %s disp {seg,led}: got %h required %h", nm, act_d, exp_d);
            end
        end
    endtask

    task automatic chk_idle(input string nm);
        chk(nm, 3'b000, 2'd0, 2'd0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Remaining three lockout cycles, then the return to RUN on the same puzzle.
    task automatic lock_hold(input logic [1:0] e_cp, e_stk, input logic [2:0] e_en,
                             input logic [31:0] e_seg, input logic [7:0] e_led);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
            chk($sformatf("lock_hold%0d", k), 3'b000, e_cp, e_stk, SEGL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("lock_exit", e_en, e_cp, e_stk, e_seg, e_led, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        puz_seg_data = {SEG2, SEG1, SEG0};
        puz_led      = {8'h33, 8'h22, 8'h11};
        start = 1'b0; abort = 1'b0; timer_expired = 1'b0; puz_clear = 3'b000; puz_fail = 3'b000;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_idle("reset");
        rst = 1'b0;

        //          st    ab    te    clr     fl      en      cp    stk   seg    led    bsy   pc    go    dchk
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001, 2'd0, 2'd0, SEG0,  8'h11, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b100, 3'b001, 2'd0, 2'd0, SEG0,  8'h11, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b001, 2'd0, 2'd0, SEG0,  8'h11, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b001, 3'b001, 3'b000, 2'd0, 2'd0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b010, 2'd1, 2'd0, SEG1,  8'h22, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b010, 3'b000, 2'd1, 2'd1, SEGL,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd1, 2'd1, SEGL,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd1, 2'd1, SEGL,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd1, 2'd1, SEGL,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b010, 2'd1, 2'd1, SEG1,  8'h22, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 2'd1, 2'd1, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b100, 2'd2, 2'd1, SEG2,  8'h33, 1'b1, 1'b0, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 2'd2, 2'd1, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd2, 2'd1, SEGD,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 2'd2, 2'd1, SEGD,  8'h00, 1'b0, 1'b1, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));

        foreach (vq[i]) begin
            step(vq[i].st, vq[i].ab, vq[i].te, vq[i].clr, vq[i].fl);
            chk($sformatf("vec%0d", i), vq[i].en, vq[i].cp, vq[i].stk, vq[i].seg, vq[i].led,
                vq[i].bsy, vq[i].pc, vq[i].go, vq[i].dchk);
        end

        // Strike-out on puzzle 0.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("so_start", 3'b001, 2'd0, 2'd0, SEG0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        chk("so_fail1", 3'b000, 2'd0, 2'd1, SEGL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        lock_hold(2'd0, 2'd1, 3'b001, SEG0, 8'h11);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        chk("so_fail2", 3'b000, 2'd0, 2'd2, SEGL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        lock_hold(2'd0, 2'd2, 3'b001, SEG0, 8'h11);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        chk("so_fail3", 3'b000, 2'd0, 2'd3, SEGO, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step((k == 0), 1'b0, 1'b0, 3'b000, 3'b001);
            chk($sformatf("so_hold%0d", k), 3'b000, 2'd0, 2'd3, SEGO, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        step(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        chk_idle("so_abort");

        // Timer expiry during LOCKOUT keeps the strike count.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        chk("te_lock_enter", 3'b000, 2'd0, 2'd1, SEGL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        chk("te_lock_over", 3'b000, 2'd0, 2'd1, SEGO, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        chk_idle("te_lock_abort");

        // Timer expiry in RUN.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b1, 3'b000, 3'b000);
        chk("te_run_over", 3'b000, 2'd0, 2'd0, SEGO, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        chk_idle("te_run_abort");

        // Abort while RUN on puzzle 2, then restart.
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b001, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b010, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("ab_run2", 3'b100, 2'd2, 2'd0, SEG2, 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        chk_idle("ab_idle");
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("ab_restart", 3'b001, 2'd0, 2'd0, SEG0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset while in LOCKOUT, then restart.
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b001);
        chk("rst_lock_enter", 3'b000, 2'd0, 2'd1, SEGL, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("rst_lock_idle");
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        chk("rst_restart", 3'b001, 2'd0, 2'd0, SEG0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
